// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone arbiters: FSM state encoding and
// one-hot helpers used by the round-robin arbiter and future interconnect arbiters.
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDX_W   = $clog2(MAX_MASTERS);

    // Index of the set bit of a one-hot vector; zero when no bit is set.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (vec[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker: grants the first requester found
// searching upward from last_ptr+1 with wrap-around.
module wb_rr_pick #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Two passes avoid a modulo on a non-power-of-two N: first the masters
    // above the last winner, then wrap to the ones at or below it.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise the untaken paths would infer latches.
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j > int'(last_ptr))) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j <= int'(last_ptr))) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave between NUM_MASTERS
// masters, with a stalled-strobe watchdog that terminates the cycle with err.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    output logic [NUM_MASTERS-1:0]              grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t             state, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, pick_gnt;
    logic [PTR_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       wd_cnt, wd_cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   sel_cyc, sel_stb;
    logic                   slave_ack, slave_err;

    wb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req      (m_cyc_i),
        .last_ptr (last_q),
        .gnt      (pick_gnt)
    );

    // grant_q is zero outside GRANT, so this AND-OR mux drives all zeros in IDLE.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                sel_cyc = sel_cyc | m_cyc_i[i];
                sel_stb = sel_stb | m_stb_i[i];
                s_we_o  = s_we_o  | m_we_i[i];
                s_adr_o = s_adr_o | m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = s_dat_o | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = s_sel_o | m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    assign s_cyc_o = sel_cyc;
    // The timeout cycle withdraws the strobe so a late ack cannot complete it.
    assign s_stb_o = sel_cyc & sel_stb & ~timeout_q;

    assign slave_ack = s_ack_i & s_stb_o;
    assign slave_err = s_err_i & s_stb_o;

    assign m_ack_o = grant_q & {NUM_MASTERS{slave_ack}};
    assign m_err_o = grant_q & {NUM_MASTERS{slave_err | timeout_q}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        last_d  = last_q;
        case (state)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = pick_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Only the owner's cyc matters; other masters wait for release.
                if (!sel_cyc) begin
                    grant_d = '0;
                    last_d  = PTR_W'(onehot_to_idx(MAX_MASTERS'(grant_q)));
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A stalled strobe counts up; the cycle that would reach the limit arms the
    // timeout unless the slave answers in that same cycle.
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = 1'b0;
        if ((state == ST_GRANT) && s_stb_o && !s_ack_i && !s_err_i) begin
            wd_cnt_d  = (wd_cnt == CNT_MAX) ? wd_cnt : wd_cnt + 1'b1;
            timeout_d = WD_EN && (wd_cnt == CNT_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= PTR_W'(NUM_MASTERS - 1);
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wd_cnt    <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
